// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - state encoding and default bus widths shared by the APB requester
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS wait-cycle watchdog, instantiated only under APB_MASTER_TIMEOUT_EN
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST_WAIT)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // Combinational so the master aborts on the very edge that ends the last wait cycle
  assign o_expire = i_en && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command port to APB SETUP/ACCESS requester
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

  apb_state_t        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_accept;

  // Ready is combinational on PREADY so a new command can chain straight into SETUP
  assign cmd_ready = (r_state == IDLE) || ((r_state == ACCESS) && PREADY);
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic r_rsp_timeout;
  logic w_expire;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk    (PCLK),
    .i_rst_n  (PRESETn),
    .i_clr    (r_state == SETUP),
    .i_en     ((r_state == ACCESS) && !PREADY),
    .o_expire (w_expire)
  );

  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_rsp_timeout <= 1'b0;
`endif
      // Address/data are only loaded on acceptance and otherwise hold, including in IDLE
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_state   <= SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_penable   <= 1'b0;
            if (cmd_valid) begin
              r_state <= SETUP;
              r_psel  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_psel  <= 1'b0;
            end
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (w_expire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
          end
`endif
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized bench for apb_master against a transaction-level schedule model
// Timeout scenarios are exercised when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  localparam int TIMEOUT = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;
    bit          err;
    int          gap;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        cur;
  bit          have_cur = 1'b0;
  bit          to_flag  = 1'b0;
  int          t0 = 0, last = -1, cyc = 0, rsp_cyc = -1;
  logic [31:0] rsp_rd;
  bit          rsp_er, rsp_to;
  logic [31:0] mem [16];
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int w, input bit err, input int gap);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.w = w; c.err = err; c.gap = gap;
    q.push_back(c);
  endtask

  // One clock: check outputs against the schedule, then drive the completer and command port
  task automatic cycle();
    bit busy, fin, ready_exp;
    @(negedge PCLK);
    cyc++;
    busy = have_cur && (cyc >= t0) && (cyc <= last);
    chk("psel", PSEL, busy);
    chk("penable", PENABLE, busy && (cyc > t0));
    chk("paddr", PADDR, have_cur ? cur.addr : 32'h0);
    if (busy) begin
      chk("pwrite", PWRITE, cur.wr);
      if (cur.wr) chk("pwdata", PWDATA, cur.wdata);
    end
    chk("rsp_valid", rsp_valid, cyc == rsp_cyc);
    chk("rsp_timeout", rsp_timeout, (cyc == rsp_cyc) && rsp_to);
    if (cyc == rsp_cyc) begin
      chk("rsp_rdata", rsp_rdata, rsp_rd);
      chk("rsp_err", rsp_err, rsp_er);
    end

    fin     = busy && (cyc == last);
    PREADY  = 1'b0;
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
    if (!busy || cyc == t0) PREADY = 1'($urandom);
    if (fin && !to_flag) begin
      PREADY  = 1'b1;
      PSLVERR = cur.err;
      if (!cur.wr) PRDATA = mem[cur.addr[5:2]];
      rsp_rd  = cur.wr ? 32'h0 : mem[cur.addr[5:2]];
      rsp_er  = cur.err;
      rsp_to  = 1'b0;
      rsp_cyc = cyc + 1;
      if (cur.wr) mem[cur.addr[5:2]] = cur.wdata;
    end else if (fin) begin
      rsp_rd  = 32'h0;
      rsp_er  = 1'b1;
      rsp_to  = 1'b1;
      rsp_cyc = cyc + 1;
    end
    ready_exp = !busy || (fin && !to_flag);

    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    if (q.size() > 0) begin
      if (q[0].gap > 0) begin
        q[0].gap = q[0].gap - 1;
      end else begin
        cmd_valid = 1'b1;
        cmd_write = q[0].wr;
        cmd_addr  = q[0].addr;
        cmd_wdata = q[0].wdata;
      end
    end
    #1;
    chk("cmd_ready", cmd_ready, ready_exp);
    if (cmd_valid && ready_exp) begin
      cur      = q.pop_front();
      have_cur = 1'b1;
      t0       = cyc + 1;
      to_flag  = TO_EN && (cur.w >= TIMEOUT);
      last     = to_flag ? (t0 + TIMEOUT) : (t0 + 1 + cur.w);
    end
  endtask

  task automatic drain();
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < 1500) begin
      cycle();
      n++;
      done = (q.size() == 0) && (!have_cur || cyc > last) && (cyc >= rsp_cyc);
    end
    chk("drain", done, 1'b1);
  endtask

  initial begin
    int n;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[8] = 32'hA5A5_A5A5;

    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    push(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 0);
    drain();
    push(1'b0, 32'h20, 32'h0, 3, 1'b0, 1);
    drain();
    push(1'b1, 32'h04, 32'h1234_5678, 0, 1'b0, 0);
    push(1'b0, 32'h08, 32'h0, 1, 1'b0, 0);
    drain();
    push(1'b1, 32'h0C, 32'hCAFE_F00D, 1, 1'b1, 0);
    push(1'b0, 32'h10, 32'h0, 0, 1'b0, 0);
    drain();
`ifdef APB_MASTER_TIMEOUT_EN
    push(1'b0, 32'h14, 32'h0, TIMEOUT, 1'b0, 0);
    push(1'b1, 32'h18, 32'h5555_AAAA, TIMEOUT - 1, 1'b0, 1);
    push(1'b0, 32'h18, 32'h0, TIMEOUT + 3, 1'b1, 0);
    push(1'b0, 32'h18, 32'h0, 0, 1'b0, 0);
    drain();
`endif

    push(1'b0, 32'h18, 32'h0, 2, 1'b0, 0);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(have_cur && cyc == t0 + 1) && n < 10);
    chk("rst_mid_access", PENABLE, 1'b1);
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", PSEL, 1'b0);
    chk("rst_mid_penable", PENABLE, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_paddr", PADDR, 32'h0);
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn  = 1'b1;
    have_cur = 1'b0;
    rsp_cyc  = -1;
    q.delete();
    #1;
    chk("rst_release_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 60; i++) begin
      push(1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom,
           $urandom_range(0, TO_EN ? 6 : 4), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
